// File: rtl/c_lfsr_check_pkg.sv
// Shared types and helpers for the LFSR pattern checker and its step function.
package c_lfsr_check_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/c_lfsr_check_step.sv
// One combinational LFSR iteration (no completion), shared by generator and checker.
module c_lfsr_step
  import c_lfsr_check_pkg::*;
#(
  parameter int width = 4
) (
  input  logic [width-1:0] q,
  input  logic [width-1:0] feedback,
  output logic [width-1:0] step
);

  // Vector bit width-1 carries stream bit 0, so the shift runs toward bit 0.
  assign step = {^(q & feedback), q[width-1:1]};

endmodule

// File: rtl/c_lfsr_check.sv
// Receive-side LFSR checker: self-syncs from received data, then free-runs and
// counts mismatches while locked.
module c_lfsr_check
  import c_lfsr_check_pkg::*;
#(
  parameter int width        = 4,
  parameter int lock_count   = 4,
  parameter int unlock_count = 4,
  parameter int count_width  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   active,
  input  logic [width-1:0]       feedback,
  input  logic                   valid,
  input  logic [width-1:0]       data,
  input  logic                   clear,
  output logic                   locked,
  output logic                   error,
  output logic [count_width-1:0] err_count
);

  localparam int cnt_w = $clog2(max_int(lock_count, unlock_count) + 1);
  localparam logic [cnt_w-1:0]       cnt_zero    = {cnt_w{1'b0}};
  localparam logic [cnt_w-1:0]       cnt_one     = cnt_w'(1);
  localparam logic [cnt_w-1:0]       lock_last   = cnt_w'(lock_count - 1);
  localparam logic [cnt_w-1:0]       unlock_last = cnt_w'(unlock_count - 1);
  localparam logic [count_width-1:0] err_zero    = {count_width{1'b0}};
  localparam logic [count_width-1:0] err_one     = count_width'(1);
  localparam logic [count_width-1:0] err_max     = {count_width{1'b1}};
  localparam logic [width-1:0]       word_zero   = {width{1'b0}};

  chk_state_e             state_q, state_d;
  logic [width-1:0]       exp_q, exp_d;
  logic [cnt_w-1:0]       match_cnt_q, match_cnt_d;
  logic [cnt_w-1:0]       miss_cnt_q, miss_cnt_d;
  logic                   have_prev_q, have_prev_d;
  logic                   locked_q, locked_d;
  logic                   error_q, error_d;
  logic [count_width-1:0] err_count_q, err_count_d;
  logic [width-1:0]       step_data_s, step_exp_s;
  logic                   data_eq_s;

  c_lfsr_step #(.width(width)) u_step_data (
    .q(data), .feedback(feedback), .step(step_data_s)
  );

  c_lfsr_step #(.width(width)) u_step_exp (
    .q(exp_q), .feedback(feedback), .step(step_exp_s)
  );

  assign data_eq_s = (data == exp_q);

  // Next-state: search/lock decision, free-running expectation, error counting.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    have_prev_d = have_prev_q;
    locked_d    = locked_q;
    error_d     = error_q;
    err_count_d = err_count_q;
    if (active) begin
      error_d = 1'b0;
      if (clear) begin
        err_count_d = err_zero;
      end else begin
        err_count_d = err_count_q;
      end
      if (valid) begin
        case (state_q)
          ST_SEARCH: begin
            exp_d       = step_data_s;
            have_prev_d = 1'b1;
            // All-zero is the lock-up word and can never build confidence.
            if (have_prev_q && data_eq_s && (data != word_zero)) begin
              if (match_cnt_q == lock_last) begin
                state_d     = ST_LOCKED;
                locked_d    = 1'b1;
                match_cnt_d = cnt_zero;
              end else begin
                match_cnt_d = match_cnt_q + cnt_one;
              end
            end else begin
              match_cnt_d = cnt_zero;
            end
          end
          ST_LOCKED: begin
            exp_d = step_exp_s;
            if (!data_eq_s) begin
              error_d = 1'b1;
              if (err_count_d != err_max) begin
                err_count_d = err_count_d + err_one;
              end else begin
                err_count_d = err_max;
              end
              if (miss_cnt_q == unlock_last) begin
                state_d     = ST_SEARCH;
                locked_d    = 1'b0;
                miss_cnt_d  = cnt_zero;
                have_prev_d = 1'b0;
              end else begin
                miss_cnt_d = miss_cnt_q + cnt_one;
              end
            end else begin
              miss_cnt_d = cnt_zero;
            end
          end
          default: begin
            state_d     = ST_SEARCH;
            locked_d    = 1'b0;
            match_cnt_d = cnt_zero;
            miss_cnt_d  = cnt_zero;
            have_prev_d = 1'b0;
          end
        endcase
      end else begin
        exp_d = exp_q;
      end
    end else begin
      error_d = error_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      exp_q       <= word_zero;
      match_cnt_q <= cnt_zero;
      miss_cnt_q  <= cnt_zero;
      have_prev_q <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= err_zero;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      have_prev_q <= have_prev_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_c_lfsr_check.sv
// Self-checking bench for c_lfsr_check: directed scenarios plus random traffic
// compared against a behavioural model of the lock/count rules.
module tb_c_lfsr_check;

  localparam int W = 4;
  localparam int LOCK = 2;
  localparam int UNLOCK = 2;
  localparam int CW = 2;
  localparam logic [W-1:0] FB = 4'b1001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          active = 1'b0;
  logic [W-1:0]  feedback = FB;
  logic          valid = 1'b0;
  logic [W-1:0]  data = 4'h0;
  logic          clear = 1'b0;
  logic          locked, error;
  logic [CW-1:0] err_count;

  int total = 0;
  int bad = 0;

  // Model state: lock flag, expected next word, consecutive run, error tally.
  bit          m_locked;
  bit          m_have;
  bit          m_error;
  int          m_run;
  int          m_cnt;
  logic [W-1:0] m_exp;

  c_lfsr_check #(.width(W), .lock_count(LOCK), .unlock_count(UNLOCK), .count_width(CW)) dut (
    .clk(clk), .reset(reset), .active(active), .feedback(feedback), .valid(valid),
    .data(data), .clear(clear), .locked(locked), .error(error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Next pattern word: stream bit 0 sits in vector bit W-1; new bit is feedback parity.
  function automatic logic [W-1:0] nxt(input logic [W-1:0] q);
    int p;
    int v;
    p = $countones(q & FB) % 2;
    v = (int'(q) / 2) + p * (1 << (W - 1));
    return W'(v);
  endfunction

  task automatic model_reset();
    m_locked = 0; m_have = 0; m_error = 0; m_run = 0; m_cnt = 0; m_exp = '0;
  endtask

  task automatic model_step(input logic a, input logic v, input logic [W-1:0] d, input logic c);
    if (a) begin
      m_error = 0;
      if (c) m_cnt = 0;
      if (v) begin
        if (!m_locked) begin
          if (m_have && d == m_exp && d != 0) begin
            m_run++;
            if (m_run == LOCK) begin m_locked = 1; m_run = 0; end
          end else begin
            m_run = 0;
          end
          m_exp = nxt(d);
          m_have = 1;
        end else begin
          if (d != m_exp) begin
            m_error = 1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            m_run++;
            if (m_run == UNLOCK) begin m_locked = 0; m_run = 0; m_have = 0; end
          end else begin
            m_run = 0;
          end
          m_exp = nxt(m_exp);
        end
      end
    end
  endtask

  task automatic cycle(input logic a, input logic v, input logic [W-1:0] d, input logic c);
    active = a; valid = v; data = d; clear = c;
    @(posedge clk);
    model_step(a, v, d, c);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; active = 1'b1; valid = 1'b0; clear = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (locked !== 1'b0 || error !== 1'b0 || err_count !== 2'd0) begin
      $display("FAIL reset: got locked=%b error=%b cnt=%0d want 0/0/0", locked, error, err_count);
      bad++;
    end
  endtask

  task automatic test_lock();
    logic [W-1:0] seq [5];
    seq[0] = 4'hF; seq[1] = 4'h7; seq[2] = 4'hB; seq[3] = 4'h5; seq[4] = 4'hA;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, seq[i], 1'b0);
      total++;
      if (locked !== (i >= 2) || error !== 1'b0 || err_count !== 2'd0) begin
        $display("FAIL lock[%0d]: got locked=%b error=%b cnt=%0d want locked=%0d 0/0",
                 i, locked, error, err_count, (i >= 2));
        bad++;
      end
    end
  endtask

  task automatic test_single_error();
    cycle(1'b1, 1'b1, 4'hC, 1'b0);
    total++;
    if (locked !== 1'b1 || error !== 1'b1 || err_count !== 2'd1) begin
      $display("FAIL single_err: got locked=%b error=%b cnt=%0d want 1/1/1", locked, error, err_count);
      bad++;
    end
    cycle(1'b1, 1'b1, 4'h6, 1'b0);
    total++;
    if (locked !== 1'b1 || error !== 1'b0 || err_count !== 2'd1) begin
      $display("FAIL single_err_after: got locked=%b error=%b cnt=%0d want 1/0/1", locked, error, err_count);
      bad++;
    end
  endtask

  task automatic test_unlock_saturate();
    logic [W-1:0] words [7];
    logic         want_lock [7];
    logic         want_err [7];
    int           want_cnt [7];
    words[0] = 4'h0; want_lock[0] = 1; want_err[0] = 1; want_cnt[0] = 2;
    words[1] = 4'h0; want_lock[1] = 0; want_err[1] = 1; want_cnt[1] = 3;
    words[2] = 4'hF; want_lock[2] = 0; want_err[2] = 0; want_cnt[2] = 3;
    words[3] = 4'h7; want_lock[3] = 0; want_err[3] = 0; want_cnt[3] = 3;
    words[4] = 4'hB; want_lock[4] = 1; want_err[4] = 0; want_cnt[4] = 3;
    words[5] = 4'h0; want_lock[5] = 1; want_err[5] = 1; want_cnt[5] = 3;
    words[6] = 4'hA; want_lock[6] = 1; want_err[6] = 0; want_cnt[6] = 3;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b1, words[i], 1'b0);
      total++;
      if (locked !== want_lock[i] || error !== want_err[i] || int'(err_count) != want_cnt[i]) begin
        $display("FAIL unlock_sat[%0d]: got locked=%b error=%b cnt=%0d want %b/%b/%0d",
                 i, locked, error, err_count, want_lock[i], want_err[i], want_cnt[i]);
        bad++;
      end
    end
  endtask

  task automatic test_zero_stream();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 4'h0, 1'b0);
      total++;
      if (locked !== 1'b0 || error !== 1'b0) begin
        $display("FAIL zero_stream[%0d]: got locked=%b error=%b want 0/0", i, locked, error);
        bad++;
      end
    end
  endtask

  task automatic test_gaps_and_freeze();
    logic [W-1:0] seq [5];
    seq[0] = 4'hF; seq[1] = 4'h7; seq[2] = 4'hB; seq[3] = 4'h5; seq[4] = 4'hA;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, seq[i], 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0);
    cycle(1'b1, 1'b1, 4'hD, 1'b0);
    total++;
    if (locked !== 1'b1 || error !== 1'b0 || err_count !== 2'd0) begin
      $display("FAIL gap: got locked=%b error=%b cnt=%0d want 1/0/0", locked, error, err_count);
      bad++;
    end
    cycle(1'b1, 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 4'h0, 1'b1);
      total++;
      if (locked !== 1'b1 || error !== 1'b1 || err_count !== 2'd1) begin
        $display("FAIL freeze[%0d]: got locked=%b error=%b cnt=%0d want 1/1/1", i, locked, error, err_count);
        bad++;
      end
    end
    cycle(1'b1, 1'b1, 4'h3, 1'b0);
    total++;
    if (locked !== 1'b1 || error !== 1'b0 || err_count !== 2'd1) begin
      $display("FAIL unfreeze: got locked=%b error=%b cnt=%0d want 1/0/1", locked, error, err_count);
      bad++;
    end
  endtask

  task automatic test_clear_and_reset();
    cycle(1'b1, 1'b1, 4'h0, 1'b1);
    total++;
    if (error !== 1'b1 || err_count !== 2'd1) begin
      $display("FAIL clear_mismatch: got error=%b cnt=%0d want 1/1", error, err_count);
      bad++;
    end
    cycle(1'b1, 1'b1, 4'h4, 1'b1);
    total++;
    if (locked !== 1'b1 || error !== 1'b0 || err_count !== 2'd0) begin
      $display("FAIL clear_match: got locked=%b error=%b cnt=%0d want 1/0/0", locked, error, err_count);
      bad++;
    end
    cycle(1'b1, 1'b1, 4'h0, 1'b0);
    do_reset();
    total++;
    if (locked !== 1'b0 || err_count !== 2'd0 || error !== 1'b0) begin
      $display("FAIL reset_locked: got locked=%b error=%b cnt=%0d want 0/0/0", locked, error, err_count);
      bad++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] gen;
    logic [W-1:0] d;
    logic         a, v, c;
    do_reset();
    gen = W'($urandom_range(15, 1));
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(7, 0) != 0);
      v = ($urandom_range(3, 0) != 0);
      c = ($urandom_range(15, 0) == 0);
      d = ($urandom_range(9, 0) == 0) ? W'($urandom_range(15, 0)) : gen;
      if ($urandom_range(99, 0) == 0) gen = W'($urandom_range(15, 1));
      cycle(a, v, d, c);
      if (a && v) gen = nxt(gen);
      total++;
      if (locked !== m_locked || error !== m_error || int'(err_count) != m_cnt) begin
        $display("FAIL random[%0d]: got locked=%b error=%b cnt=%0d want %b/%b/%0d",
                 i, locked, error, err_count, m_locked, m_error, m_cnt);
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_single_error();
    test_unlock_saturate();
    test_zero_stream();
    test_gaps_and_freeze();
    test_clear_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
